xgmii_pattern_bist: RTL and testbench

XGMII_PATTERN_BIST -- requirements
Module: xgmii_pattern_bist

---
 rtl/xgmii_pattern_bist.sv | 201 ++++++++++++++++++++
 tb/tb_xgmii_pattern_bist.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_pattern_bist.sv
// XGMII pattern BIST: cyclic fixed-byte pattern generator plus a lock/track checker.
// Latency: tx words are registered one cycle after k. Status and counts update one cycle after the rx word.
// Backpressure: none. rx_valid=0 simply freezes the checker; the generator free-runs while enabled.
module xgmii_pattern_bist #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_PATTERNS    = 6,
  parameter int LOCK_COUNT      = 4,
  parameter int UNLOCK_ERRORS   = 3,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       clear_counts,
  output logic [DATA_WIDTH-1:0]      xgmii_txd,
  output logic [CTRL_WIDTH-1:0]      xgmii_txc,
  input  logic [DATA_WIDTH-1:0]      xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0]      xgmii_rxc,
  input  logic                       rx_valid,
  output logic                       locked,
  output logic                       mismatch,
  output logic [ERR_COUNT_WIDTH-1:0] error_count,
  output logic [ERR_COUNT_WIDTH-1:0] word_count,
  output logic [1:0]                 state
);

  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Byte table for the pattern cycle; the two control-coded bytes carry txc all-ones.
  function automatic logic [7:0] pat_byte(input logic [2:0] k);
    case (k)
      3'd0:    pat_byte = 8'hFF;
      3'd1:    pat_byte = 8'h00;
      3'd2:    pat_byte = 8'h55;
      3'd3:    pat_byte = 8'hAA;
      3'd4:    pat_byte = 8'hFE;
      3'd5:    pat_byte = 8'h07;
      3'd6:    pat_byte = 8'h33;
      default: pat_byte = 8'hCC;
    endcase
  endfunction

  function automatic logic pat_ctl(input logic [2:0] k);
    pat_ctl = (k == 3'd4) || (k == 3'd5);
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] k);
    next_idx = (k == 3'(NUM_PATTERNS - 1)) ? 3'd0 : k + 3'd1;
  endfunction

  logic [2:0]                 k_q;
  logic [DATA_WIDTH-1:0]      txd_q;
  logic [CTRL_WIDTH-1:0]      txc_q;

  state_t                     state_q;
  logic [2:0]                 exp_q;
  logic [7:0]                 run_q;
  logic [7:0]                 bad_q;
  logic [ERR_COUNT_WIDTH-1:0] err_q;
  logic [ERR_COUNT_WIDTH-1:0] word_q;
  logic                       mismatch_q;
  logic                       locked_q;

  logic                       hit;
  logic [2:0]                 hit_idx;
  logic                       exp_hit;
  logic [ERR_COUNT_WIDTH-1:0] err_d;
  logic [ERR_COUNT_WIDTH-1:0] word_d;
  logic [7:0]                 bad_d;

  // Generator: walk the pattern table while enabled, otherwise send idle (07 / ctrl) and park k at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= 3'd0;
      txd_q <= {LANES{8'h07}};
      txc_q <= {CTRL_WIDTH{1'b1}};
    end else if (enable) begin
      txd_q <= {LANES{pat_byte(k_q)}};
      txc_q <= {CTRL_WIDTH{pat_ctl(k_q)}};
      k_q   <= next_idx(k_q);
    end else begin
      k_q   <= 3'd0;
      txd_q <= {LANES{8'h07}};
      txc_q <= {CTRL_WIDTH{1'b1}};
    end
  end

  // Classify the received word: which pattern (if any) it equals, and whether that is the expected one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    exp_hit = 1'b0;
    for (int j = 0; j < NUM_PATTERNS; j++) begin
      if (xgmii_rxd == {LANES{pat_byte(3'(j))}} &&
          xgmii_rxc == {CTRL_WIDTH{pat_ctl(3'(j))}}) begin
        if (!hit) begin
          hit     = 1'b1;
          hit_idx = 3'(j);
        end
        if (3'(j) == exp_q) exp_hit = 1'b1;
      end
    end
  end

  // Saturating increments for the counters and the bad-run length.
  always_comb begin
    err_d  = (err_q  == {ERR_COUNT_WIDTH{1'b1}}) ? err_q  : err_q  + 1'b1;
    word_d = (word_q == {ERR_COUNT_WIDTH{1'b1}}) ? word_q : word_q + 1'b1;
    bad_d  = (bad_q  == 8'hFF) ? bad_q : bad_q + 8'd1;
  end

  // Checker FSM: IDLE -> HUNT (align and build a run) -> LOCKED (track, count, maybe fall back).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      exp_q      <= 3'd0;
      run_q      <= 8'd0;
      bad_q      <= 8'd0;
      err_q      <= '0;
      word_q     <= '0;
      mismatch_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      if (!enable) begin
        state_q  <= ST_IDLE;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_HUNT;
            run_q   <= 8'd0;
            exp_q   <= 3'd0;
          end
          ST_HUNT: begin
            if (run_q >= 8'(LOCK_COUNT)) begin
              // Run complete last cycle: lock now, but keep the index moving with the stream.
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              bad_q    <= 8'd0;
              if (rx_valid) exp_q <= next_idx(exp_q);
            end else if (rx_valid) begin
              if (exp_hit) begin
                run_q <= run_q + 8'd1;
                exp_q <= next_idx(exp_q);
              end else if (hit) begin
                run_q <= 8'd1;
                exp_q <= next_idx(hit_idx);
              end else begin
                run_q <= 8'd0;
              end
            end
          end
          ST_LOCKED: begin
            if (rx_valid) begin
              exp_q <= next_idx(exp_q);
              if (exp_hit) begin
                word_q <= word_d;
                bad_q  <= 8'd0;
              end else begin
                err_q      <= err_d;
                mismatch_q <= 1'b1;
                bad_q      <= bad_d;
                if (UNLOCK_ERRORS != 0 && bad_d == 8'(UNLOCK_ERRORS)) begin
                  state_q  <= ST_HUNT;
                  locked_q <= 1'b0;
                  run_q    <= 8'd0;
                end
              end
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
      // Clear overrides any same-cycle increment; the mismatch pulse above is unaffected.
      if (clear_counts) begin
        err_q  <= '0;
        word_q <= '0;
      end
    end
  end

  assign xgmii_txd   = txd_q;
  assign xgmii_txc   = txc_q;
  assign locked      = locked_q;
  assign mismatch    = mismatch_q;
  assign error_count = err_q;
  assign word_count  = word_q;
  assign state       = state_q;

endmodule

// File: tb/tb_xgmii_pattern_bist.sv
// Bench for xgmii_pattern_bist: default instance plus a 4-bit-counter, never-unlock instance.
// Both share tx-derived loopback from a queue so rx_valid gaps stretch the loop delay.
// Expected values come from a cycle model of the pattern rules kept in this file.
module tb_xgmii_pattern_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear_counts;
  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic        rx_valid;

  logic [63:0] txd_a, txd_b;
  logic [7:0]  txc_a, txc_b;
  logic        locked_a, locked_b, mm_a, mm_b;
  logic [15:0] ec_a, wc_a;
  logic [3:0]  ec_b, wc_b;
  logic [1:0]  st_a, st_b;

  always #5 clk = ~clk;

  xgmii_pattern_bist dut_a (
    .clk(clk), .rst(rst), .enable(enable), .clear_counts(clear_counts),
    .xgmii_txd(txd_a), .xgmii_txc(txc_a), .xgmii_rxd(rxd), .xgmii_rxc(rxc),
    .rx_valid(rx_valid), .locked(locked_a), .mismatch(mm_a),
    .error_count(ec_a), .word_count(wc_a), .state(st_a)
  );

  xgmii_pattern_bist #(.ERR_COUNT_WIDTH(4), .UNLOCK_ERRORS(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .clear_counts(clear_counts),
    .xgmii_txd(txd_b), .xgmii_txc(txc_b), .xgmii_rxd(rxd), .xgmii_rxc(rxc),
    .rx_valid(rx_valid), .locked(locked_b), .mismatch(mm_b),
    .error_count(ec_b), .word_count(wc_b), .state(st_b)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  byte unsigned pat_tab [8] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hFE, 8'h07, 8'h33, 8'hCC};
  int          lock_n  = 4;
  int          unl   [2] = '{3, 0};
  int          cmax  [2] = '{65535, 15};
  int          m_k;
  logic [63:0] m_txd;
  logic [7:0]  m_txc;
  int          m_st [2];
  int          m_exp[2];
  int          m_run[2];
  int          m_bad[2];
  int          m_ec [2];
  int          m_wc [2];
  bit          m_mm [2];
  logic [71:0] loopq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int which_pat(input logic [63:0] d, input logic [7:0] c);
    for (int j = 0; j < 6; j++) begin
      logic [7:0] cc;
      cc = (j == 4 || j == 5) ? 8'hFF : 8'h00;
      if (d == {8{pat_tab[j]}} && c == cc) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_txd = {8{8'h07}};
    m_txc = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_exp[i] = 0; m_run[i] = 0; m_bad[i] = 0;
      m_ec[i] = 0; m_wc[i] = 0; m_mm[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit en, input bit clr, input bit vld,
                            input logic [63:0] d, input logic [7:0] c);
    int j;
    j = which_pat(d, c);
    if (en) begin
      m_txd = {8{pat_tab[m_k]}};
      m_txc = (m_k == 4 || m_k == 5) ? 8'hFF : 8'h00;
      m_k   = (m_k + 1) % 6;
    end else begin
      m_txd = {8{8'h07}};
      m_txc = 8'hFF;
      m_k   = 0;
    end
    for (int i = 0; i < 2; i++) begin
      m_mm[i] = 1'b0;
      if (!en) m_st[i] = 0;
      else if (m_st[i] == 0) begin
        m_st[i] = 1; m_run[i] = 0; m_exp[i] = 0;
      end else if (m_st[i] == 1) begin
        if (m_run[i] >= lock_n) begin
          m_st[i] = 2; m_bad[i] = 0;
          if (vld) m_exp[i] = (m_exp[i] + 1) % 6;
        end else if (vld) begin
          if (j == m_exp[i]) begin m_run[i]++; m_exp[i] = (m_exp[i] + 1) % 6; end
          else if (j >= 0) begin m_run[i] = 1; m_exp[i] = (j + 1) % 6; end
          else m_run[i] = 0;
        end
      end else if (vld) begin
        bit ok;
        ok = (j == m_exp[i]);
        m_exp[i] = (m_exp[i] + 1) % 6;
        if (ok) begin
          if (m_wc[i] < cmax[i]) m_wc[i]++;
          m_bad[i] = 0;
        end else begin
          if (m_ec[i] < cmax[i]) m_ec[i]++;
          m_mm[i] = 1'b1;
          m_bad[i]++;
          if (unl[i] != 0 && m_bad[i] >= unl[i]) begin m_st[i] = 1; m_run[i] = 0; end
        end
      end
      if (clr) begin m_ec[i] = 0; m_wc[i] = 0; end
    end
  endtask

  task automatic check_all();
    chk("txd_a", txd_a, m_txd);
    chk("txc_a", {56'd0, txc_a}, {56'd0, m_txc});
    chk("txd_b", txd_b, m_txd);
    chk("state_a", {62'd0, st_a}, 64'(m_st[0]));
    chk("locked_a", {63'd0, locked_a}, 64'(m_st[0] == 2));
    chk("mismatch_a", {63'd0, mm_a}, {63'd0, m_mm[0]});
    chk("errcnt_a", {48'd0, ec_a}, 64'(m_ec[0]));
    chk("wordcnt_a", {48'd0, wc_a}, 64'(m_wc[0]));
    chk("state_b", {62'd0, st_b}, 64'(m_st[1]));
    chk("locked_b", {63'd0, locked_b}, 64'(m_st[1] == 2));
    chk("mismatch_b", {63'd0, mm_b}, {63'd0, m_mm[1]});
    chk("errcnt_b", {60'd0, ec_b}, 64'(m_ec[1]));
    chk("wordcnt_b", {60'd0, wc_b}, 64'(m_wc[1]));
  endtask

  task automatic do_reset(input bit en);
    @(negedge clk);
    rst = 1'b1; enable = en; clear_counts = 1'b0; rx_valid = 1'b1;
    rxd = {$urandom, $urandom}; rxc = 8'($urandom);
    model_reset();
    loopq.delete();
    @(posedge clk); #1;
    check_all();
  endtask

  // One clock of stimulus: tx goes into the loop queue, rx takes the oldest entry when valid.
  task automatic cycle(input bit en, input bit clr, input bit vld, input bit cor);
    logic [71:0] w;
    @(negedge clk);
    rst = 1'b0;
    loopq.push_back({m_txc, m_txd});
    if (vld) begin
      w   = loopq.pop_front();
      rxd = w[63:0] ^ {63'd0, cor};
      rxc = w[71:64];
    end else begin
      rxd = {$urandom, $urandom};
      rxc = 8'($urandom);
    end
    enable = en; clear_counts = clr; rx_valid = vld;
    model_step(en, clr, vld, rxd, rxc);
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    int snap;
    rst = 1'b1; enable = 1'b0; clear_counts = 1'b0; rx_valid = 1'b0; rxd = '0; rxc = '0;
    model_reset();

    // Reset state
    do_reset(1'b0);
    do_reset(1'b0);
    chk("rst_txd", txd_a, 64'h0707070707070707);
    chk("rst_state", {62'd0, st_a}, 64'd0);

    // Clean loopback: first word is pattern 0, lock after 4 words plus a cycle
    cycle(1, 0, 1, 0);
    chk("first_txd", txd_a, 64'hFFFFFFFFFFFFFFFF);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0);
    chk("not_yet_locked", {63'd0, locked_a}, 64'd0);
    cycle(1, 0, 1, 0);
    chk("locked_after_4", {63'd0, locked_a}, 64'd1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0);
    chk("clean_errors", {48'd0, ec_a}, 64'd0);

    // Single bit-0 flip while locked
    cycle(1, 0, 1, 1);
    chk("single_err_pulse", {63'd0, mm_a}, 64'd1);
    chk("single_err_count", {48'd0, ec_a}, 64'd1);
    cycle(1, 0, 1, 0);
    chk("single_err_still_locked", {63'd0, locked_a}, 64'd1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);

    // Three consecutive bad words drop lock, then relock on good data
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1);
    chk("unlock_state", {62'd0, st_a}, 64'd1);
    chk("unlock_errcnt", {48'd0, ec_a}, 64'd4);
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
    chk("relock", {63'd0, locked_a}, 64'd1);

    // Long error burst: 4-bit counter saturates, never-unlock instance stays locked
    for (int i = 0; i < 20; i++) cycle(1, 0, 1, 1);
    chk("sat_errcnt_b", {60'd0, ec_b}, 64'd15);
    chk("sat_locked_b", {63'd0, locked_b}, 64'd1);
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);

    // rx_valid gap with loopback delayed to match
    snap = m_wc[0];
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      chk("gap_wc_frozen", {48'd0, wc_a}, 64'(snap));
    end
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 0);
    chk("gap_locked", {63'd0, locked_a}, 64'd1);

    // Clear coinciding with a counted mismatch
    cycle(1, 1, 1, 1);
    chk("clear_wins", {48'd0, ec_a}, 64'd0);
    chk("clear_pulse", {63'd0, mm_a}, 64'd1);
    for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 8, $urandom_range(0, 7) == 0);

    // Fresh lock, then enable drop holds counts
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 1);
    snap = m_ec[0];
    cycle(0, 0, 1, 0);
    chk("disable_idle", {62'd0, st_a}, 64'd0);
    chk("disable_hold_ec", {48'd0, ec_a}, 64'(snap));
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
    chk("pre_reset_locked", {63'd0, locked_a}, 64'd1);

    // Reset wins while locked and enabled
    do_reset(1'b1);
    chk("reset_in_lock", {62'd0, st_a}, 64'd0);
    chk("reset_in_lock_wc", {48'd0, wc_a}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
